apb_requester_arbiter: RTL and testbench

//   Shares one APB completer (e.g. the 32x32 register-file slave) between N local requesters.

---
 rtl/apb_requester_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_apb_requester_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester_arbiter.sv
// Round-robin arbiter that shares one APB completer between N local requesters.
// Sequences IDLE->SETUP->ACCESS, returns read data/status, aborts on PREADY timeout.

module apb_req_lane #(
  parameter int N   = 4,
  parameter int AW  = 5,
  parameter int DW  = 32,
  parameter int IW  = 2,
  parameter int IDX = 0
) (
  input  logic [N-1:0]  req_valid,
  input  logic [IW-1:0] arb_ptr,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_write,
  output logic [AW-1:0] gnt_addr,
  output logic [DW-1:0] gnt_wdata
);
  // This lane wins when it is valid and no valid lane sits closer to the pointer.
  always_comb begin
    int my_dist;
    int d;
    my_dist = (IDX + N - int'(arb_ptr)) % N;
    d       = 0;
    gnt     = req_valid[IDX];
    for (int j = 0; j < N; j++) begin
      d = (j + N - int'(arb_ptr)) % N;
      if (req_valid[j] && (d < my_dist)) gnt = 1'b0;
    end
  end

  assign gnt_idx   = gnt ? IW'(IDX) : '0;
  assign gnt_write = gnt & req_write;
  assign gnt_addr  = gnt ? req_addr  : '0;
  assign gnt_wdata = gnt ? req_wdata : '0;
endmodule

module apb_requester_arbiter #(
  parameter int N       = 4,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            pclk,
  input  logic            prst,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_write,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic [AW-1:0]   paddr,
  output logic            pselx,
  output logic            penable,
  output logic            pwrite,
  output logic [DW-1:0]   pwdata,
  input  logic            pready,
  input  logic [DW-1:0]   prdata
);
  localparam int IW      = (N > 1) ? $clog2(N) : 1;
  localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_LAST);
  localparam bit   TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          pwrite_q, pwrite_d;
  logic [N-1:0]  req_ready_q, req_ready_d;
  logic [N-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [IW-1:0]                next_ptr, arb_ptr;
  logic [N-1:0]                 lane_gnt;
  logic [N-1:0][IW-1:0]         lane_idx;
  logic [N-1:0]                 lane_write;
  logic [N-1:0][AW-1:0]         lane_addr;
  logic [N-1:0][DW-1:0]         lane_wdata;
  logic [IW-1:0]                win_idx;
  logic                         win_write;
  logic [AW-1:0]                win_addr;
  logic [DW-1:0]                win_wdata;

  // On completion the next winner is chosen with the already-advanced pointer.
  assign next_ptr = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
  assign arb_ptr  = (state_q == ACCESS) ? next_ptr : rr_ptr_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    apb_req_lane #(.N(N), .AW(AW), .DW(DW), .IW(IW), .IDX(i)) u_lane (
      .req_valid (req_valid),
      .arb_ptr   (arb_ptr),
      .req_write (req_write[i]),
      .req_addr  (req_addr[i*AW +: AW]),
      .req_wdata (req_wdata[i*DW +: DW]),
      .gnt       (lane_gnt[i]),
      .gnt_idx   (lane_idx[i]),
      .gnt_write (lane_write[i]),
      .gnt_addr  (lane_addr[i]),
      .gnt_wdata (lane_wdata[i])
    );
  end

  always_comb begin
    win_idx   = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_write = |lane_write;
    for (int i = 0; i < N; i++) begin
      win_idx   = win_idx   | lane_idx[i];
      win_addr  = win_addr  | lane_addr[i];
      win_wdata = win_wdata | lane_wdata[i];
    end
  end

  always_comb begin
    logic load;
    load        = 1'b0;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) load = 1'b1;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (pready) begin
          for (int i = 0; i < N; i++) rsp_valid_d[i] = (gnt_idx_q == IW'(i));
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rr_ptr_d    = next_ptr;
          state_d     = IDLE;
          if (|req_valid) load = 1'b1;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          for (int i = 0; i < N; i++) rsp_valid_d[i] = (gnt_idx_q == IW'(i));
          rsp_err_d = 1'b1;
          rr_ptr_d  = next_ptr;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      paddr_d     = win_addr;
      pwdata_d    = win_wdata;
      pwrite_d    = win_write;
      gnt_idx_d   = win_idx;
      req_ready_d = lane_gnt;
      cnt_d       = '0;
      state_d     = SETUP;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign pselx     = (state_q != IDLE);
  assign penable   = (state_q == ACCESS);
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Scoreboard bench: requesters and a wait-state completer are driven here, a monitor
// checks grants, APB phases and responses against a rule-level model.

module tb_apb_requester_arbiter;
  localparam int N       = 4;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;

  logic            pclk;
  logic            prst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   paddr;
  logic            pselx;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic            pready;
  logic [DW-1:0]   prdata;

  apb_requester_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .prst(prst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  exp_t          exp_q [N][$];
  int            gnt_log [$];
  logic [DW-1:0] rdat [32];
  int            waits_tab [32];
  int            vectors;
  int            miscompares;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Completer: pready on the (waits+1)-th ACCESS cycle of each address; noise elsewhere.
  initial begin
    int acc;
    acc    = 0;
    pready = 1'b0;
    prdata = '0;
    forever begin
      @(negedge pclk);
      if (pselx && penable) begin
        if (acc == waits_tab[paddr]) begin
          pready = 1'b1;
          prdata = rdat[paddr];
        end else begin
          pready = 1'b0;
          prdata = $urandom;
        end
        acc++;
      end else begin
        acc    = 0;
        pready = 1'($urandom_range(0, 1));
        prdata = $urandom;
      end
    end
  end

  // Monitor / reference model
  int              m_cyc, m_gnt_cyc, m_cur, m_rr, m_g, m_idx;
  bit              m_busy, m_was_busy, m_done, m_done_err, m_can;
  exp_t            m_cur_e;
  logic [N-1:0]    m_snap, m_exp_rsp, m_exp_gnt;
  logic            m_rst;
  logic [AW+DW:0]  m_prev;

  initial begin
    m_cyc = 0; m_gnt_cyc = 0; m_cur = 0; m_rr = 0; m_busy = 1'b0; m_prev = '0;
    forever begin
      @(posedge pclk);
      m_snap = req_valid;
      m_rst  = prst;
      m_cyc++;
      #1;
      if (m_rst) begin
        chk("reset_ctl", {req_ready, rsp_valid, rsp_err, pselx, penable, pwrite}, '0);
        chk("reset_paddr_pwdata", {paddr, pwdata}, '0);
        chk("reset_rdata", rsp_rdata, '0);
        m_busy = 1'b0;
        m_rr   = 0;
      end else begin
        m_was_busy = m_busy;
        m_done     = 1'b0;
        m_done_err = 1'b0;
        m_exp_rsp  = '0;
        if (m_busy && (m_cyc - m_gnt_cyc == m_cur_e.lat)) begin
          m_exp_rsp[m_cur] = 1'b1;
          m_done     = 1'b1;
          m_done_err = m_cur_e.err;
        end
        chk("rsp_valid", rsp_valid, m_exp_rsp);
        if (m_done) begin
          chk("rsp_rdata", rsp_rdata, m_cur_e.rdata);
          chk("rsp_err", rsp_err, m_cur_e.err);
          m_busy = 1'b0;
          m_rr   = (m_cur + 1) % N;
        end
        m_can     = m_was_busy ? (m_done && !m_done_err) : 1'b1;
        m_g       = -1;
        m_exp_gnt = '0;
        if (m_can) begin
          for (int k = 0; k < N; k++) begin
            m_idx = (m_rr + k) % N;
            if (m_g < 0 && m_snap[m_idx]) m_g = m_idx;
          end
        end
        if (m_g >= 0) m_exp_gnt[m_g] = 1'b1;
        chk("req_ready", req_ready, m_exp_gnt);
        if (m_g >= 0) begin
          if (exp_q[m_g].size() == 0) begin
            chk("grant_without_request", 64'd0, 64'd1);
          end else begin
            m_cur_e = exp_q[m_g].pop_front();
            chk("latched_paddr", paddr, m_cur_e.addr);
            chk("latched_pwrite", pwrite, m_cur_e.we);
            chk("latched_pwdata", pwdata, m_cur_e.wdata);
          end
          m_busy    = 1'b1;
          m_cur     = m_g;
          m_gnt_cyc = m_cyc;
          gnt_log.push_back(m_g);
        end
        if (m_busy) begin
          chk("pselx_busy", pselx, 1);
          chk("penable_phase", penable, (m_cyc != m_gnt_cyc));
        end else begin
          chk("apb_idle", {pselx, penable}, '0);
          chk("idle_hold", {paddr, pwrite, pwdata}, m_prev);
        end
      end
      m_prev = {paddr, pwrite, pwdata};
    end
  end

  task automatic issue(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    int   w;
    w       = waits_tab[a];
    e.addr  = a;
    e.we    = we;
    e.wdata = d;
    e.err   = (w >= TIMEOUT);
    e.rdata = (e.err || we) ? '0 : rdat[a];
    e.lat   = e.err ? TIMEOUT + 1 : w + 2;
    exp_q[i].push_back(e);
    req_valid[i]             = 1'b1;
    req_write[i]             = we;
    req_addr[i*AW +: AW]     = a;
    req_wdata[i*DW +: DW]    = d;
  endtask

  task automatic tick(input int prob, input bit fair);
    @(negedge pclk);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        if (req_ready[i]) req_valid[i] = 1'b0;
      end else if (prob > 0 && $urandom_range(0, 99) < prob) begin
        issue(i, 1'($urandom_range(0, 1)), fair ? AW'(i) : AW'($urandom_range(0, 31)), $urandom);
      end
    end
  endtask

  task automatic drain(input string name);
    int  n;
    bit  idle;
    n    = 0;
    idle = 1'b0;
    while (!idle && n < 400) begin
      tick(0, 0);
      n++;
      idle = (req_valid == '0) && !m_busy;
      for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) idle = 1'b0;
    end
    chk({name, "_drain"}, idle, 1);
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    for (int a = 0; a < 32; a++) begin
      rdat[a]      = $urandom;
      waits_tab[a] = $urandom_range(0, 5);
    end
    for (int a = 0; a < 4; a++) waits_tab[a] = 0;
    waits_tab[7] = 2;
    rdat[7]      = 32'h1234;
    waits_tab[9] = 5;
    prst      = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge pclk);
    prst = 1'b0;

    // all four held valid from pointer 0: grants must rotate 0,1,2,3,0
    gnt_log.delete();
    for (int c = 0; c < 22; c++) tick(100, 1);
    drain("fair");
    chk("fair_len", gnt_log.size() >= 5, 1);
    for (int k = 0; k < 5; k++)
      chk("fair_order", (k < gnt_log.size()) ? gnt_log[k] : -1, k % 4);

    issue(0, 1'b1, 5'd3, 32'hDEADBEEF);
    drain("single_write");
    issue(1, 1'b0, 5'd7, '0);
    drain("read_2wait");
    issue(2, 1'b0, 5'd9, '0);
    drain("timeout");

    // reset while in ACCESS; the in-flight transfer vanishes, pointer restarts at 0
    issue(1, 1'b0, 5'd7, '0);
    n = 0;
    while (!(pselx && penable) && n < 20) begin
      tick(0, 0);
      n++;
    end
    chk("reach_access", pselx && penable, 1);
    issue(2, 1'b1, 5'd1, 32'hCAFE0001);
    issue(0, 1'b0, 5'd2, '0);
    prst = 1'b1;
    tick(0, 0);
    prst = 1'b0;
    gnt_log.delete();
    drain("reset_access");
    chk("post_reset_first_gnt", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

    repeat (20) tick(0, 0);

    repeat (2500) tick(30, 0);
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
